// File: rtl/note_lookup_arbiter.sv
// note_lookup_arbiter: round-robin arbiter that lets several channel
// sequencers share one synchronous note-to-phase-delta table. Each winning
// request is looked up in three cycles (grant, read, capture) and the table
// word is parked in a per-channel holding register with a one-cycle ack.
module note_lookup_arbiter #(
  parameter int NUM_CH = 4,
  parameter int NOTE_W = 6,
  parameter int DATA_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH*NOTE_W-1:0] i_req_note,
  output logic [NUM_CH-1:0]        o_ack,
  output logic [NUM_CH*DATA_W-1:0] o_phase_delta,
  output logic [NUM_CH-1:0]        o_valid,
  output logic [NOTE_W-1:0]        o_tbl_note,
  output logic                     o_tbl_rd,
  input  logic [DATA_W-1:0]        i_tbl_data,
  output logic                     o_busy
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  // Round-robin search pointer and the grant latched for the lookup in flight.
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    ptr_nxt;
  logic [NUM_CH-1:0]   gnt_oh;

  // Combinational arbitration results.
  logic [NUM_CH-1:0]   elig;
  logic                pick_any;
  logic [PTR_W-1:0]    pick_idx;
  logic [NUM_CH-1:0]   pick_oh;
  logic [NOTE_W-1:0]   pick_note;
  logic [PTR_W-1:0]    scan_idx;

  // FSM strobes.
  logic                grant;
  logic                capture;

  // Channel index reached by stepping 'off' places upward from 'base',
  // wrapping at NUM_CH (which need not be a power of two).
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int               off);
    int s;
    s = 32'(base) + off;
    if (s >= NUM_CH) begin
      s = s - NUM_CH;
    end
    return PTR_W'(s);
  endfunction

  // A channel that is being acked this cycle still has its request up; mask
  // it so the same request is never granted twice.
  assign elig = i_req & ~o_ack;

  // Round-robin pick: first eligible channel at or above ptr, modulo NUM_CH.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      scan_idx = wrap_add(ptr, k);
      if (!pick_any && elig[scan_idx]) begin
        pick_any = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  // One-hot grant, the winner's note code and the pointer value after it.
  always_comb begin
    pick_oh   = '0;
    pick_note = '0;
    if (pick_any) begin
      pick_oh[pick_idx] = 1'b1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (pick_oh[c]) begin
        pick_note = i_req_note[c*NOTE_W +: NOTE_W];
      end
    end
    if (32'(pick_idx) == NUM_CH - 1) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = pick_idx + PTR_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and decoded strobes: grant in IDLE, read strobe in READ,
  // capture of table data at the end of CAPTURE.
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    capture   = 1'b0;
    o_tbl_rd  = 1'b0;
    o_busy    = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_any) begin
          grant     = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        o_tbl_rd  = 1'b1;
        o_busy    = 1'b1;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        o_busy    = 1'b1;
        capture   = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // On grant: advance the pointer, remember the winner and sample its note
  // once; later note changes cannot disturb the lookup in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ptr        <= '0;
      gnt_oh     <= '0;
      o_tbl_note <= '0;
    end else if (grant) begin
      ptr        <= ptr_nxt;
      gnt_oh     <= pick_oh;
      o_tbl_note <= pick_note;
    end
  end

  // Ack pulses for exactly the cycle after CAPTURE; valid is sticky.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ack   <= '0;
      o_valid <= '0;
    end else begin
      o_ack <= capture ? gnt_oh : '0;
      if (capture) begin
        o_valid <= o_valid | gnt_oh;
      end
    end
  end

  // Holding registers: only the granted channel's word is overwritten, with
  // the table data passed through untouched.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_phase_delta <= '0;
    end else if (capture) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (gnt_oh[c]) begin
          o_phase_delta[c*DATA_W +: DATA_W] <= i_tbl_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_note_lookup_arbiter.sv
// Testbench for note_lookup_arbiter: directed scenarios followed by random
// channel traffic, all compared against a transaction-timing reference model.
module tb_note_lookup_arbiter;

  localparam int NUM_CH = 4;
  localparam int NOTE_W = 6;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] TBL_BASE = 32'hA000_0000;

  logic                     i_clk = 1'b0;
  logic                     i_reset = 1'b1;
  logic [NUM_CH-1:0]        i_req = '0;
  logic [NUM_CH*NOTE_W-1:0] i_req_note = '0;
  logic [NUM_CH-1:0]        o_ack;
  logic [NUM_CH*DATA_W-1:0] o_phase_delta;
  logic [NUM_CH-1:0]        o_valid;
  logic [NOTE_W-1:0]        o_tbl_note;
  logic                     o_tbl_rd;
  logic [DATA_W-1:0]        i_tbl_data = '0;
  logic                     o_busy;

  int n_checks = 0;
  int n_errors = 0;

  note_lookup_arbiter #(
    .NUM_CH(NUM_CH),
    .NOTE_W(NOTE_W),
    .DATA_W(DATA_W)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_req         (i_req),
    .i_req_note    (i_req_note),
    .o_ack         (o_ack),
    .o_phase_delta (o_phase_delta),
    .o_valid       (o_valid),
    .o_tbl_note    (o_tbl_note),
    .o_tbl_rd      (o_tbl_rd),
    .i_tbl_data    (i_tbl_data),
    .o_busy        (o_busy)
  );

  always #5 i_clk = ~i_clk;

  // Table model: valid word one cycle after a read strobe, garbage otherwise.
  always @(posedge i_clk) begin
    if (o_tbl_rd) i_tbl_data <= TBL_BASE | DATA_W'(o_tbl_note);
    else          i_tbl_data <= DATA_W'($urandom);
  end

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a lookup granted in cycle n reads in n+1, is busy in
  // n+1..n+2 and completes (ack + register update) in n+3.
  logic [DATA_W-1:0]        m_pd [NUM_CH];
  logic [NUM_CH-1:0]        m_valid = '0;
  logic [NUM_CH-1:0]        m_ack = '0;
  logic [NOTE_W-1:0]        m_note = '0;
  int                       m_ptr = 0;
  int                       m_cyc = 0;
  int                       job_t0 = 0;
  int                       job_ch = 0;
  bit                       job_on = 1'b0;
  logic [NUM_CH*DATA_W-1:0] exp_pd;
  int                       mc;

  always @(negedge i_clk) begin
    m_ack = '0;
    if (i_reset) begin
      for (int c = 0; c < NUM_CH; c++) m_pd[c] = '0;
      m_valid = '0;
      m_note  = '0;
      m_ptr   = 0;
      job_on  = 1'b0;
    end else if (job_on && m_cyc == job_t0 + 3) begin
      m_pd[job_ch]    = TBL_BASE | DATA_W'(m_note);
      m_valid[job_ch] = 1'b1;
      m_ack[job_ch]   = 1'b1;
      job_on          = 1'b0;
    end
    for (int c = 0; c < NUM_CH; c++) exp_pd[c*DATA_W +: DATA_W] = m_pd[c];
    check("ack",      256'(o_ack),         256'(m_ack));
    check("valid",    256'(o_valid),       256'(m_valid));
    check("pd",       256'(o_phase_delta), 256'(exp_pd));
    check("tbl_note", 256'(o_tbl_note),    256'(m_note));
    check("busy",     256'(o_busy),        256'(job_on && m_cyc > job_t0));
    check("tbl_rd",   256'(o_tbl_rd),      256'(job_on && m_cyc == job_t0 + 1));
    if (!i_reset && !job_on) begin
      for (int k = 0; k < NUM_CH; k++) begin
        mc = (m_ptr + k) % NUM_CH;
        if (i_req[mc] && !m_ack[mc]) begin
          job_on = 1'b1;
          job_t0 = m_cyc;
          job_ch = mc;
          m_note = i_req_note[mc*NOTE_W +: NOTE_W];
          m_ptr  = (mc + 1) % NUM_CH;
          break;
        end
      end
    end
    m_cyc++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    i_req   = '0;
    tick();
    tick();
    i_reset = 1'b0;
  endtask

  task automatic set_note(input int c, input logic [NOTE_W-1:0] n);
    i_req_note[c*NOTE_W +: NOTE_W] = n;
  endtask

  function automatic logic [DATA_W-1:0] pd_of(input int c);
    return o_phase_delta[c*DATA_W +: DATA_W];
  endfunction

  int ag [NUM_CH];
  int r;
  int nacks;
  int rd_cnt;
  int ack_cnt;
  logic [NUM_CH-1:0] exp_ack;

  initial begin
    do_reset();
    check("rst_ack",   256'(o_ack),         256'(0));
    check("rst_valid", 256'(o_valid),       256'(0));
    check("rst_pd",    256'(o_phase_delta), 256'(0));
    check("rst_busy",  256'(o_busy),        256'(0));

    // 1: single request from ch2
    i_req[2] = 1'b1; set_note(2, 6'd17);
    tick();
    check("t1_rd",   256'(o_tbl_rd),   256'(1));
    check("t1_note", 256'(o_tbl_note), 256'(17));
    tick(); tick();
    check("t1_ack",   256'(o_ack),   256'(4'b0100));
    check("t1_pd",    256'(pd_of(2)), 256'(32'hA000_0011));
    check("t1_valid", 256'(o_valid), 256'(4'b0100));
    i_req = '0;
    tick(); tick();

    // 2: all channels at once, served in index order every 3 cycles
    do_reset();
    for (int c = 0; c < NUM_CH; c++) set_note(c, NOTE_W'(c + 1));
    i_req = '1;
    for (int t = 1; t <= 14; t++) begin
      tick();
      exp_ack = (t % 3 == 0 && t >= 3 && t <= 12) ? NUM_CH'(1 << (t / 3 - 1)) : '0;
      check("t2_ack", 256'(o_ack), 256'(exp_ack));
      i_req = i_req & ~o_ack;
    end
    check("t2_pd", 256'(o_phase_delta),
          256'({32'hA000_0004, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001}));

    // 3: ch0 and ch3 continuously requesting alternate, ptr wraps 3 -> 0
    do_reset();
    set_note(0, 6'd11); set_note(3, 6'd13);
    i_req = 4'b1001;
    nacks = 0;
    for (int t = 1; t <= 24; t++) begin
      tick();
      if (o_ack != '0) begin
        check("t3_order", 256'(o_ack), 256'((nacks % 2 == 0) ? 4'b0001 : 4'b1000));
        nacks++;
      end
    end
    check("t3_nacks", 256'(nacks), 256'(8));
    i_req = '0;
    tick(); tick(); tick();

    // 4: ack mask - high through the ack cycle only gives one lookup
    do_reset();
    i_req[1] = 1'b1; set_note(1, 6'd7);
    rd_cnt = 0; ack_cnt = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      rd_cnt  += int'(o_tbl_rd);
      ack_cnt += int'(o_ack[1]);
      if (t == 4) i_req[1] = 1'b0;
    end
    check("t4_rd1",  256'(rd_cnt),  256'(1));
    check("t4_ack1", 256'(ack_cnt), 256'(1));
    //   held beyond the cycle after ack: a second lookup
    i_req[1] = 1'b1; set_note(1, 6'd8);
    rd_cnt = 0; ack_cnt = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      rd_cnt  += int'(o_tbl_rd);
      ack_cnt += int'(o_ack[1]);
      if (t == 7) i_req[1] = 1'b0;
    end
    check("t4_rd2",  256'(rd_cnt),   256'(2));
    check("t4_ack2", 256'(ack_cnt),  256'(2));
    check("t4_pd",   256'(pd_of(1)), 256'(32'hA000_0008));

    // 5: note changes after grant are ignored
    do_reset();
    i_req[0] = 1'b1; set_note(0, 6'd5);
    tick();
    set_note(0, 6'd9);
    check("t5_note", 256'(o_tbl_note), 256'(5));
    tick(); tick();
    check("t5_ack", 256'(o_ack),    256'(4'b0001));
    check("t5_pd",  256'(pd_of(0)), 256'(32'hA000_0005));
    i_req = '0;
    tick(); tick();

    // 6: reset during CAPTURE abandons the lookup and restarts from ptr 0
    i_req[2] = 1'b1; set_note(2, 6'd22);
    tick();
    i_req[1] = 1'b1; set_note(1, 6'd21);
    i_req[3] = 1'b1; set_note(3, 6'd23);
    tick();
    check("t6_capture", 256'({o_busy, o_tbl_rd}), 256'(2'b10));
    i_reset = 1'b1;
    #1;
    check("t6_rst_out", 256'({o_ack, o_valid, o_tbl_note, o_tbl_rd, o_busy}), 256'(0));
    check("t6_rst_pd",  256'(o_phase_delta), 256'(0));
    tick();
    check("t6_noack", 256'(o_ack), 256'(0));
    tick();
    i_reset = 1'b0;
    tick();
    check("t6_rd",   256'(o_tbl_rd),   256'(1));
    check("t6_note", 256'(o_tbl_note), 256'(21));
    for (int t = 0; t < 12; t++) begin
      tick();
      i_req = i_req & ~o_ack;
    end
    check("t6_valid", 256'(o_valid), 256'(4'b1110));
    check("t6_pd", 256'(o_phase_delta),
          256'({32'hA000_0017, 32'hA000_0016, 32'hA000_0015, 32'h0}));

    // Random traffic with occasional asynchronous resets
    for (int c = 0; c < NUM_CH; c++) ag[c] = 0;
    i_req = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      if (i_reset) i_reset = 1'b0;
      else if ($urandom_range(399) == 0) i_reset = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        case (ag[c])
          0: begin
            if ($urandom_range(2) == 0) begin
              i_req[c] = 1'b1;
              set_note(c, NOTE_W'($urandom));
              ag[c] = 1;
            end
          end
          1: begin
            if (o_ack[c]) begin
              r = int'($urandom_range(2));
              if (r == 0) begin
                i_req[c] = 1'b0;
                ag[c] = 0;
              end else if (r == 1) begin
                ag[c] = 2;
              end else begin
                set_note(c, NOTE_W'($urandom));
              end
            end
          end
          default: begin
            i_req[c] = 1'b0;
            ag[c] = 0;
          end
        endcase
      end
    end
    i_reset = 1'b0;
    i_req = '0;
    for (int t = 0; t < 6; t++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
